// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner: synchronizes, debounces and resolves paddle buttons into game pad codes plus a press pulse.
module pad_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [1:0] Left_pad_control,
  output logic [1:0] Right_pad_control,
  output logic       press_pulse,
  output logic [3:0] btn_state
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, state_q, state_d;
  logic [3:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] left_q, left_d, right_q, right_d;
  logic       pulse_q, pulse_d;
  always_comb begin
    sync1_d  = {btn_r_dn, btn_r_up, btn_l_dn, btn_l_up} ^ {4{BTN_ACTIVE_LOW}};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : stable_q[i];
      cnt_d[i]    = (sync2_q[i] == stable_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + CNT_WIDTH'(1);
    end
    // both directions held resolves to hold (00)
    left_d  = {stable_q[1] & ~stable_q[0], stable_q[0] & ~stable_q[1]};
    right_d = {stable_q[3] & ~stable_q[2], stable_q[2] & ~stable_q[3]};
    state_d = stable_q;
    pulse_d = |(stable_q & ~state_q);
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      state_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
    end
  end
  assign Left_pad_control  = left_q;
  assign Right_pad_control = right_q;
  assign btn_state         = state_q;
  assign press_pulse       = pulse_q;
endmodule
